// File: rtl/branch_prediction_controller_pkg.sv
// Shared types for the fetch-stage branch predictor: direction-counter encoding
// and its saturating update function.
package branch_prediction_controller_pkg;

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'd0,
        WEAKLY_NOT_TAKEN   = 2'd1,
        WEAKLY_TAKEN       = 2'd2,
        STRONGLY_TAKEN     = 2'd3
    } bp_state_e;

    function automatic bp_state_e bp_next(input bp_state_e s, input logic taken);
        bp_state_e n;
        case (s)
            STRONGLY_NOT_TAKEN: n = taken ? WEAKLY_NOT_TAKEN : STRONGLY_NOT_TAKEN;
            WEAKLY_NOT_TAKEN:   n = taken ? WEAKLY_TAKEN     : STRONGLY_NOT_TAKEN;
            WEAKLY_TAKEN:       n = taken ? STRONGLY_TAKEN   : WEAKLY_NOT_TAKEN;
            STRONGLY_TAKEN:     n = taken ? STRONGLY_TAKEN   : WEAKLY_TAKEN;
            default:            n = WEAKLY_NOT_TAKEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_prediction_controller_if.sv
// Fetch/commit-side signal bundle of the branch predictor; master drives the
// pipeline inputs, slave is the predictor itself.
interface branch_prediction_controller_if #(
    parameter int BIT_COUNT = 32
);
    logic [BIT_COUNT-1:0] PC_I;
    logic                 Stall_I;
    logic                 Stall_R;
    logic                 Flush_R;
    logic                 Flush_C;
    logic                 BranchResolve_C;
    logic                 Taken_C;
    logic [BIT_COUNT-1:0] Target_C;
    logic [BIT_COUNT-1:0] PC_C;
    logic                 Predict;
    logic [BIT_COUNT-1:0] Prediction;
    logic                 PredictionCorrect_C;
    logic                 Mispredict_C;
    logic [15:0]          BranchCount;
    logic [15:0]          MispredictCount;

    modport master (
        output PC_I, Stall_I, Stall_R, Flush_R, Flush_C,
               BranchResolve_C, Taken_C, Target_C, PC_C,
        input  Predict, Prediction, PredictionCorrect_C, Mispredict_C,
               BranchCount, MispredictCount
    );

    modport slave (
        input  PC_I, Stall_I, Stall_R, Flush_R, Flush_C,
               BranchResolve_C, Taken_C, Target_C, PC_C,
        output Predict, Prediction, PredictionCorrect_C, Mispredict_C,
               BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_prediction_controller_bp_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one training
// port that performs the read-modify-write of the addressed entry internally.
module branch_prediction_controller_bp_table
    import branch_prediction_controller_pkg::*;
#(
    parameter int BIT_COUNT   = 32,
    parameter int ENTRY_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] rd_pc,
    output logic                 rd_hit,
    output bp_state_e            rd_state,
    output logic [BIT_COUNT-1:0] rd_target,
    input  logic                 wr_en,
    input  logic [BIT_COUNT-1:0] wr_pc,
    input  logic                 wr_taken,
    input  logic [BIT_COUNT-1:0] wr_target
);
    localparam int INDEX_BITS = $clog2(ENTRY_COUNT);
    localparam int TAG_BITS   = BIT_COUNT - INDEX_BITS - 2;

    logic                 valid_r  [ENTRY_COUNT];
    logic [TAG_BITS-1:0]  tag_r    [ENTRY_COUNT];
    logic [BIT_COUNT-1:0] target_r [ENTRY_COUNT];
    bp_state_e            state_r  [ENTRY_COUNT];

    logic [INDEX_BITS-1:0] rd_idx_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic                  wr_hit_s;
    logic                  unused_pc_bits_s;

    assign rd_idx_s  = rd_pc[INDEX_BITS+1:2];
    assign wr_idx_s  = wr_pc[INDEX_BITS+1:2];
    assign rd_hit    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_pc[BIT_COUNT-1:INDEX_BITS+2]);
    assign rd_state  = state_r[rd_idx_s];
    assign rd_target = target_r[rd_idx_s];
    assign wr_hit_s  = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_pc[BIT_COUNT-1:INDEX_BITS+2]);
    assign unused_pc_bits_s = ^{rd_pc[1:0], wr_pc[1:0]};

    // Entry storage: clear on reset, train hits, allocate only on taken misses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_BITS{1'b0}};
                target_r[i] <= {BIT_COUNT{1'b0}};
                state_r[i]  <= WEAKLY_NOT_TAKEN;
            end
        end else if (wr_en) begin
            if (wr_hit_s) begin
                state_r[wr_idx_s] <= bp_next(state_r[wr_idx_s], wr_taken);
                if (wr_taken) begin
                    target_r[wr_idx_s] <= wr_target;
                end
            end else if (wr_taken) begin
                valid_r[wr_idx_s]  <= 1'b1;
                tag_r[wr_idx_s]    <= wr_pc[BIT_COUNT-1:INDEX_BITS+2];
                target_r[wr_idx_s] <= wr_target;
                state_r[wr_idx_s]  <= WEAKLY_TAKEN;
            end
        end
    end

endmodule

// File: rtl/branch_prediction_controller.sv
// Fetch-stage branch predictor: BTB lookup, prediction tracking through I->R->C,
// commit-stage compare, table training and saturating performance counters.
module branch_prediction_controller
    import branch_prediction_controller_pkg::*;
#(
    parameter int BIT_COUNT   = 32,
    parameter int ENTRY_COUNT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    branch_prediction_controller_if.slave bus
);
    localparam logic [BIT_COUNT-1:0] ZERO_ADDR = {BIT_COUNT{1'b0}};

    logic                 lookup_hit_s;
    bp_state_e            lookup_state_s;
    logic [BIT_COUNT-1:0] lookup_target_s;
    logic                 predict_s;
    logic [BIT_COUNT-1:0] prediction_s;
    logic                 correct_s;
    logic                 mispredict_s;
    logic                 train_s;
    logic                 unused_target_bit_s;

    logic                 r_valid_r, r_predict_r, c_valid_r, c_predict_r;
    logic [BIT_COUNT-1:0] r_target_r, c_target_r;
    logic [15:0]          branch_count_r, mispredict_count_r;

    branch_prediction_controller_bp_table #(
        .BIT_COUNT   (BIT_COUNT),
        .ENTRY_COUNT (ENTRY_COUNT)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_pc     (bus.PC_I),
        .rd_hit    (lookup_hit_s),
        .rd_state  (lookup_state_s),
        .rd_target (lookup_target_s),
        .wr_en     (train_s),
        .wr_pc     (bus.PC_C),
        .wr_taken  (bus.Taken_C),
        .wr_target (bus.Target_C)
    );

    // Exactly one training event per branch: the cycle it leaves C.
    assign train_s             = bus.BranchResolve_C && !bus.Stall_R;
    assign unused_target_bit_s = lookup_target_s[0];

    // Lookup: predict taken only on a tag hit with a taken-leaning counter.
    always_comb begin
        predict_s    = 1'b0;
        prediction_s = ZERO_ADDR;
        if (lookup_hit_s && (lookup_state_s == WEAKLY_TAKEN || lookup_state_s == STRONGLY_TAKEN)) begin
            predict_s    = 1'b1;
            prediction_s = {lookup_target_s[BIT_COUNT-1:1], 1'b0};
        end else begin
            predict_s    = 1'b0;
            prediction_s = ZERO_ADDR;
        end
    end

    // Compare: a resolving branch with no tracked prediction forces a redirect.
    always_comb begin
        correct_s    = 1'b0;
        mispredict_s = 1'b0;
        if (reset || !bus.BranchResolve_C) begin
            correct_s    = 1'b0;
            mispredict_s = 1'b0;
        end else if (!c_valid_r) begin
            correct_s    = 1'b0;
            mispredict_s = 1'b1;
        end else begin
            correct_s    = (c_predict_r && bus.Taken_C && (c_target_r == bus.Target_C)) ||
                           (!c_predict_r && !bus.Taken_C);
            mispredict_s = !correct_s;
        end
    end

    // Tracking registers: flush beats stall in both stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_r   <= 1'b0;
            r_predict_r <= 1'b0;
            r_target_r  <= ZERO_ADDR;
            c_valid_r   <= 1'b0;
            c_predict_r <= 1'b0;
            c_target_r  <= ZERO_ADDR;
        end else begin
            if (bus.Flush_R) begin
                r_valid_r   <= 1'b0;
                r_predict_r <= 1'b0;
                r_target_r  <= ZERO_ADDR;
            end else if (!bus.Stall_I) begin
                r_valid_r   <= 1'b1;
                r_predict_r <= predict_s;
                r_target_r  <= prediction_s;
            end
            if (bus.Flush_C) begin
                c_valid_r   <= 1'b0;
                c_predict_r <= 1'b0;
                c_target_r  <= ZERO_ADDR;
            end else if (!bus.Stall_R) begin
                c_valid_r   <= r_valid_r;
                c_predict_r <= r_predict_r;
                c_target_r  <= r_target_r;
            end
        end
    end

    // Performance counters, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_r     <= 16'h0000;
            mispredict_count_r <= 16'h0000;
        end else if (train_s) begin
            if (branch_count_r != 16'hFFFF) begin
                branch_count_r <= branch_count_r + 16'h0001;
            end
            if (mispredict_s && (mispredict_count_r != 16'hFFFF)) begin
                mispredict_count_r <= mispredict_count_r + 16'h0001;
            end
        end
    end

    assign bus.Predict             = predict_s;
    assign bus.Prediction          = prediction_s;
    assign bus.PredictionCorrect_C = correct_s;
    assign bus.Mispredict_C        = mispredict_s;
    assign bus.BranchCount         = branch_count_r;
    assign bus.MispredictCount     = mispredict_count_r;

endmodule

// File: tb/tb_branch_prediction_controller.sv
// Directed, table-driven bench for branch_prediction_controller with
// hand-computed expectations for lookup, tracking, compare, training and counters.
module tb_branch_prediction_controller;

    typedef struct {
        logic        stall_i, stall_r, flush_r, flush_c, resolve, taken;
        logic [31:0] pc_i, pc_c, target;
        logic        exp_p;
        logic [31:0] exp_pred;
        logic        exp_ok, exp_mis;
        logic [15:0] exp_bc, exp_mc;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    vec_t vecs[$];
    vec_t seqs[$];

    branch_prediction_controller_if #(.BIT_COUNT(32)) bif ();

    branch_prediction_controller #(
        .BIT_COUNT   (32),
        .ENTRY_COUNT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic si, input logic sr, input logic fr, input logic fc,
                                input logic res, input logic tk, input logic [31:0] pc_i,
                                input logic [31:0] pc_c, input logic [31:0] tgt, input logic p,
                                input logic [31:0] pred, input logic ok, input logic mis,
                                input logic [15:0] bc, input logic [15:0] mc);
        vec_t v;
        v.stall_i = si; v.stall_r = sr; v.flush_r = fr; v.flush_c = fc;
        v.resolve = res; v.taken = tk; v.pc_i = pc_i; v.pc_c = pc_c; v.target = tgt;
        v.exp_p = p; v.exp_pred = pred; v.exp_ok = ok; v.exp_mis = mis;
        v.exp_bc = bc; v.exp_mc = mc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic p, input logic [31:0] pred,
                                 input logic ok, input logic mis, input logic [15:0] bc,
                                 input logic [15:0] mc);
        chk({nm, ".predict"},    {31'd0, bif.Predict},             {31'd0, p});
        chk({nm, ".prediction"}, bif.Prediction,                   pred);
        chk({nm, ".correct"},    {31'd0, bif.PredictionCorrect_C}, {31'd0, ok});
        chk({nm, ".mispredict"}, {31'd0, bif.Mispredict_C},        {31'd0, mis});
        chk({nm, ".bcount"},     {16'd0, bif.BranchCount},         {16'd0, bc});
        chk({nm, ".mcount"},     {16'd0, bif.MispredictCount},     {16'd0, mc});
    endtask

    task automatic drive(input vec_t v);
        bif.Stall_I = v.stall_i; bif.Stall_R = v.stall_r;
        bif.Flush_R = v.flush_r; bif.Flush_C = v.flush_c;
        bif.BranchResolve_C = v.resolve; bif.Taken_C = v.taken;
        bif.PC_I = v.pc_i; bif.PC_C = v.pc_c; bif.Target_C = v.target;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        #1;
        check_outputs(nm, v.exp_p, v.exp_pred, v.exp_ok, v.exp_mis, v.exp_bc, v.exp_mc);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive(mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h100,32'h100,32'h180,
                 1'b0,32'h0,1'b0,1'b0,16'd0,16'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("in_reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
        bif.BranchResolve_C = 1'b0;
        bif.Taken_C = 1'b0;
        reset = 1'b0;

        // Fields: si sr fr fc res tk pc_i pc_c target | predict prediction ok mis bc mc
        vecs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 0,32'h000,0,0,16'd0, 16'd0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h200,32'h000,32'h000, 0,32'h000,0,0,16'd0, 16'd0));
        vecs.push_back(mk(0,0,0,0,1,1,32'h100,32'h100,32'h180, 0,32'h000,0,1,16'd0, 16'd0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 1,32'h180,0,0,16'd1, 16'd1));
        vecs.push_back(mk(0,0,0,0,1,1,32'h100,32'h100,32'h180, 1,32'h180,0,1,16'd1, 16'd1));
        vecs.push_back(mk(0,0,0,0,1,1,32'h100,32'h100,32'h180, 1,32'h180,1,0,16'd2, 16'd2));
        vecs.push_back(mk(0,0,0,0,1,0,32'h100,32'h100,32'h000, 1,32'h180,0,1,16'd3, 16'd2));
        vecs.push_back(mk(0,0,0,0,1,0,32'h100,32'h100,32'h000, 1,32'h180,0,1,16'd4, 16'd3));
        vecs.push_back(mk(0,0,0,0,1,0,32'h100,32'h100,32'h000, 0,32'h000,0,1,16'd5, 16'd4));
        vecs.push_back(mk(0,0,0,0,1,0,32'h100,32'h100,32'h000, 0,32'h000,0,1,16'd6, 16'd5));
        vecs.push_back(mk(0,0,0,0,1,0,32'h100,32'h100,32'h000, 0,32'h000,1,0,16'd7, 16'd6));
        vecs.push_back(mk(0,0,0,0,1,1,32'h100,32'h100,32'h180, 0,32'h000,0,1,16'd8, 16'd6));
        vecs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 0,32'h000,0,0,16'd9, 16'd7));
        vecs.push_back(mk(0,0,0,0,1,1,32'h100,32'h100,32'h180, 0,32'h000,0,1,16'd9, 16'd7));
        vecs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 1,32'h180,0,0,16'd10,16'd8));
        vecs.push_back(mk(0,0,0,0,0,0,32'h300,32'h000,32'h000, 0,32'h000,0,0,16'd10,16'd8));
        vecs.push_back(mk(0,0,0,0,1,1,32'h400,32'h100,32'h1C0, 0,32'h000,0,1,16'd10,16'd8));
        vecs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 1,32'h1C0,0,0,16'd11,16'd9));
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Flush_C with a prediction in R, then a resolve with no tracked entry.
        seqs.push_back(mk(0,0,0,1,0,0,32'h104,32'h000,32'h000, 0,32'h000,0,0,16'd11,16'd9));
        seqs.push_back(mk(0,0,0,1,0,0,32'h104,32'h000,32'h000, 0,32'h000,0,0,16'd11,16'd9));
        seqs.push_back(mk(0,0,0,0,1,0,32'h104,32'h800,32'h000, 0,32'h000,0,1,16'd11,16'd9));
        // Stall_R held three cycles over a resolving branch: one training event.
        seqs.push_back(mk(0,1,0,0,1,1,32'h104,32'h104,32'h140, 0,32'h000,0,1,16'd12,16'd10));
        seqs.push_back(mk(0,1,0,0,1,1,32'h104,32'h104,32'h140, 0,32'h000,0,1,16'd12,16'd10));
        seqs.push_back(mk(0,1,0,0,1,1,32'h104,32'h104,32'h140, 0,32'h000,0,1,16'd12,16'd10));
        seqs.push_back(mk(0,0,0,0,1,1,32'h104,32'h104,32'h140, 0,32'h000,0,1,16'd12,16'd10));
        seqs.push_back(mk(0,0,0,0,0,0,32'h104,32'h000,32'h000, 1,32'h140,0,0,16'd13,16'd11));
        seqs.push_back(mk(0,0,0,0,0,0,32'h100,32'h000,32'h000, 1,32'h1C0,0,0,16'd13,16'd11));
        // Stalled, correctly predicted branch just before reset is asserted.
        seqs.push_back(mk(0,1,0,0,1,1,32'h100,32'h104,32'h140, 1,32'h1C0,1,0,16'd13,16'd11));
        foreach (seqs[i]) apply(seqs[i], $sformatf("seq%0d", i));

        #1;
        reset = 1'b1;
        #1;
        check_outputs("reset_mid_stall", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        bif.BranchResolve_C = 1'b0;
        bif.Stall_R = 1'b0;
        reset = 1'b0;
        #1;
        check_outputs("after_reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
